// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect response path.
// Contents:
//   ARB_FIXED / ARB_RR : arbitration mode encodings for ARB_MODE.
//   W_MID_DEF          : default width of the master-ID field.
//   mid_field()        : extracts the MID field sitting just above the
//                        transaction-ID bits of a slave-side ID.
package axi_ic_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam int W_MID_DEF = 2;

    function automatic logic [7:0] mid_field(input logic [63:0] sid,
                                             input int          w_id,
                                             input int          w_mid);
        logic [63:0] mask;
        mask = (64'd1 << w_mid) - 64'd1;
        return 8'((sid >> w_id) & mask);
    endfunction

endpackage

// File: rtl/axi_s2m_router_n_if.sv
// Master-facing B and R response channels of the slave-to-master router.
//   slave  : router view (drives responses, receives ready).
//   master : AXI master view (receives responses, drives ready).
interface axi_s2m_router_n_if #(
    parameter int W_ID   = 4,
    parameter int W_SID  = 8,
    parameter int W_DATA = 32
);
    logic [W_ID-1:0]   M_BID;
    logic [1:0]        M_BRESP;
    logic              M_BVALID;
    logic              M_BREADY;
    logic [W_SID-1:0]  M_RSID;
    logic [W_DATA-1:0] M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RLAST;
    logic              M_RVALID;
    logic              M_RREADY;

    modport slave (
        output M_BID, M_BRESP, M_BVALID,
        input  M_BREADY,
        output M_RSID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        input  M_RREADY
    );

    modport master (
        input  M_BID, M_BRESP, M_BVALID,
        output M_BREADY,
        input  M_RSID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        output M_RREADY
    );
endinterface

// File: rtl/axi_rr_lock_arb.sv
// Fixed-priority / round-robin arbiter with optional burst lock.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   mode      : ARB_FIXED (lowest index wins) or ARB_RR (first at/above ptr)
//   req       : eligible requests used while unlocked
//   hold_req  : requests of the locked source, ignoring eligibility
//   accept    : a beat from the granted source was taken this cycle
//   last      : the accepted beat ends the burst (LOCK=1 only)
//   grant     : one-hot grant, zero when nothing is requested
//
// lock state | meaning
// -----------+--------------------------------------------------
// unlocked   | grant follows req, mode and ptr every cycle
// locked     | grant pinned to held source until its last beat
module axi_rr_lock_arb
    import axi_ic_pkg::*;
#(
    parameter int N    = 4,
    parameter bit LOCK = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic [N-1:0] hold_req,
    input  logic         accept,
    input  logic         last,
    output logic [N-1:0] grant
);
    localparam int W_IDX = (N > 1) ? $clog2(N) : 1;

    logic [W_IDX-1:0] ptr;
    logic [W_IDX-1:0] held;
    logic             locked;
    logic [W_IDX-1:0] idx;
    logic [W_IDX-1:0] g_idx;

    always_comb begin
        grant = '0;
        g_idx = '0;
        idx   = '0;
        if (locked) begin
            if (hold_req[held]) begin
                grant[held] = 1'b1;
                g_idx       = held;
            end
        end else begin
            // Scan from the far end so the nearest requester overwrites last.
            for (int i = N - 1; i >= 0; i--) begin
                case (mode)
                    ARB_FIXED: idx = W_IDX'(i);
                    ARB_RR:    idx = W_IDX'((int'(ptr) + i) % N);
                    default:   idx = W_IDX'(i);
                endcase
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    g_idx      = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            held   <= '0;
            locked <= 1'b0;
        end else if (accept) begin
            if (!LOCK || last) begin
                locked <= 1'b0;
                ptr    <= W_IDX'((int'(g_idx) + 1) % N);
            end else if (!locked) begin
                locked <= 1'b1;
                held   <= g_idx;
            end
        end
    end

endmodule

// File: rtl/axi_s2m_router_n.sv
// Slave-to-master response router for one master port. Collects B and R
// beats from NUM_S slaves plus the default slave (index NUM_S), keeps those
// whose MID field matches M_MID, arbitrates per channel and presents each
// channel through a 2-entry skid buffer with registered outputs.
// Ports:
//   AXI_CLK, AXI_RST : clock, synchronous active-high reset
//   M_MID            : this master's ID
//   ARB_MODE         : 0 fixed priority, 1 round-robin
//   R_ORDER_MASK     : per-slave R eligibility (default slave always eligible)
//   m                : master-facing B/R channels
//   S_B*, S_R*       : flattened slave-side channels, slave k in slice k
module axi_s2m_router_n
    import axi_ic_pkg::*;
#(
    parameter int NUM_S  = 3,
    parameter int W_CID  = 4,
    parameter int W_ID   = 4,
    parameter int W_MID  = W_MID_DEF,
    parameter int W_DATA = 32,
    parameter int W_SID  = W_CID + W_ID
) (
    input  logic                          AXI_CLK,
    input  logic                          AXI_RST,
    input  logic [W_MID-1:0]              M_MID,
    input  logic                          ARB_MODE,
    input  logic [NUM_S-1:0]              R_ORDER_MASK,
    axi_s2m_router_n_if.slave             m,
    input  logic [(NUM_S+1)*W_SID-1:0]    S_BID,
    input  logic [(NUM_S+1)*2-1:0]        S_BRESP,
    input  logic [NUM_S:0]                S_BVALID,
    output logic [NUM_S:0]                S_BREADY,
    input  logic [(NUM_S+1)*W_SID-1:0]    S_RID,
    input  logic [(NUM_S+1)*W_DATA-1:0]   S_RDATA,
    input  logic [(NUM_S+1)*2-1:0]        S_RRESP,
    input  logic [NUM_S:0]                S_RLAST,
    input  logic [NUM_S:0]                S_RVALID,
    output logic [NUM_S:0]                S_RREADY
);
    localparam int N     = NUM_S + 1;
    localparam int W_BPL = W_ID + 2;
    localparam int W_RPL = W_SID + W_DATA + 3;

    logic [N-1:0]     bmid_ok, rmid_ok, breq, rreq_raw, rreq, bgrant, rgrant;
    logic [W_BPL-1:0] b_in, b_mem0, b_mem1;
    logic [W_RPL-1:0] r_in, r_mem0, r_mem1;
    logic [1:0]       bcount, rcount;
    logic             b_push, b_pop, r_push, r_pop;

    always_comb begin
        bmid_ok = '0;
        rmid_ok = '0;
        b_in    = '0;
        r_in    = '0;
        for (int k = 0; k < N; k++) begin
            bmid_ok[k] = mid_field(64'(S_BID[k*W_SID +: W_SID]), W_ID, W_MID) == 8'(M_MID);
            rmid_ok[k] = mid_field(64'(S_RID[k*W_SID +: W_SID]), W_ID, W_MID) == 8'(M_MID);
            if (bgrant[k])
                b_in = {S_BID[k*W_SID +: W_ID], S_BRESP[k*2 +: 2]};
            if (rgrant[k])
                r_in = {S_RID[k*W_SID +: W_SID], S_RDATA[k*W_DATA +: W_DATA],
                        S_RRESP[k*2 +: 2], S_RLAST[k]};
        end
    end

    assign breq     = S_BVALID & bmid_ok;
    assign rreq_raw = S_RVALID & rmid_ok;
    assign rreq     = rreq_raw & {1'b1, R_ORDER_MASK};

    axi_rr_lock_arb #(.N(N), .LOCK(1'b0)) u_b_arb (
        .clk(AXI_CLK), .rst(AXI_RST), .mode(ARB_MODE), .req(breq),
        .hold_req(breq), .accept(b_push), .last(1'b1), .grant(bgrant)
    );

    axi_rr_lock_arb #(.N(N), .LOCK(1'b1)) u_r_arb (
        .clk(AXI_CLK), .rst(AXI_RST), .mode(ARB_MODE), .req(rreq),
        .hold_req(rreq_raw), .accept(r_push), .last(r_in[0]), .grant(rgrant)
    );

    // Ready depends only on registered count, never on M_xREADY.
    assign S_BREADY = bgrant & {N{(bcount != 2'd2) && !AXI_RST}};
    assign S_RREADY = rgrant & {N{(rcount != 2'd2) && !AXI_RST}};
    assign b_push   = |(S_BREADY & S_BVALID);
    assign r_push   = |(S_RREADY & S_RVALID);
    assign b_pop    = (bcount != 2'd0) && m.M_BREADY;
    assign r_pop    = (rcount != 2'd0) && m.M_RREADY;

    // Shift-style skid buffers: mem0 is always the head, so outputs come
    // straight from flops. Push together with pop only happens at count 1.
    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            bcount <= '0;
            b_mem0 <= '0;
            b_mem1 <= '0;
        end else begin
            case ({b_push, b_pop})
                2'b10: begin
                    if (bcount == 2'd0) b_mem0 <= b_in;
                    else                b_mem1 <= b_in;
                    bcount <= bcount + 2'd1;
                end
                2'b01: begin
                    b_mem0 <= b_mem1;
                    bcount <= bcount - 2'd1;
                end
                2'b11:   b_mem0 <= b_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            rcount <= '0;
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else begin
            case ({r_push, r_pop})
                2'b10: begin
                    if (rcount == 2'd0) r_mem0 <= r_in;
                    else                r_mem1 <= r_in;
                    rcount <= rcount + 2'd1;
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    rcount <= rcount - 2'd1;
                end
                2'b11:   r_mem0 <= r_in;
                default: ;
            endcase
        end
    end

    assign m.M_BID    = b_mem0[W_BPL-1:2];
    assign m.M_BRESP  = b_mem0[1:0];
    assign m.M_BVALID = (bcount != 2'd0);
    assign {m.M_RSID, m.M_RDATA, m.M_RRESP, m.M_RLAST} = r_mem0;
    assign m.M_RVALID = (rcount != 2'd0);

endmodule

// File: tb/tb_axi_s2m_router_n.sv
module tb_axi_s2m_router_n;
    import axi_ic_pkg::*;

    localparam int NUM_S = 3, N = 4, W_CID = 4, W_ID = 4, W_MID = 2;
    localparam int W_DATA = 32, W_SID = W_CID + W_ID;
    localparam int W_RPL = W_SID + W_DATA + 3;

    logic                 AXI_CLK = 1'b0;
    logic                 AXI_RST;
    logic [W_MID-1:0]     M_MID;
    logic                 ARB_MODE;
    logic [NUM_S-1:0]     R_ORDER_MASK;
    logic [N*W_SID-1:0]   S_BID, S_RID;
    logic [N*2-1:0]       S_BRESP, S_RRESP;
    logic [N-1:0]         S_BVALID, S_BREADY, S_RLAST, S_RVALID, S_RREADY;
    logic [N*W_DATA-1:0]  S_RDATA;

    axi_s2m_router_n_if #(.W_ID(W_ID), .W_SID(W_SID), .W_DATA(W_DATA)) m ();

    axi_s2m_router_n #(
        .NUM_S(NUM_S), .W_CID(W_CID), .W_ID(W_ID), .W_MID(W_MID),
        .W_DATA(W_DATA), .W_SID(W_SID)
    ) dut (
        .AXI_CLK(AXI_CLK), .AXI_RST(AXI_RST), .M_MID(M_MID), .ARB_MODE(ARB_MODE),
        .R_ORDER_MASK(R_ORDER_MASK), .m(m.slave),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    always #5 AXI_CLK = ~AXI_CLK;

    int errors = 0;
    int checks = 0;

    // Slave-side stimulus state: each slave holds its beat until taken.
    bit               bv[N];
    logic [W_SID-1:0] bsid[N];
    logic [1:0]       bresp[N];
    bit               rv[N];
    logic [W_SID-1:0] rsid[N];
    logic [W_DATA-1:0] rdat[N];
    logic [1:0]       rresp[N];
    int               rleft[N];

    // Reference model state.
    int  bptr, rptr, rheld, bcnt, rcnt;
    bit  rlocked, rst_seen, rr_hold_low;
    int  stall_b, stall_r;
    logic [W_ID+1:0]  bexp[$];
    logic [W_RPL-1:0] rexp[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mid_of(input logic [W_SID-1:0] s);
        return (int'(s) >> W_ID) % (1 << W_MID);
    endfunction

    function automatic int pick(input bit [N-1:0] req, input int ptr, input bit rr);
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = rr ? (ptr + i) % N : i;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W_SID-1:0] rand_sid();
        logic [W_SID-1:0] s;
        s = W_SID'($urandom);
        s[W_ID +: W_MID] = ($urandom % 5 == 0) ? W_MID'($urandom) : M_MID;
        return s;
    endfunction

    task automatic model_clear();
        bexp.delete();
        rexp.delete();
        bcnt = 0; rcnt = 0; bptr = 0; rptr = 0; rheld = 0; rlocked = 1'b0;
        for (int k = 0; k < N; k++) begin
            bv[k] = 1'b0; rv[k] = 1'b0; rleft[k] = 0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            S_BVALID[k] = bv[k];
            S_BID[k*W_SID +: W_SID] = bsid[k];
            S_BRESP[k*2 +: 2] = bresp[k];
            S_RVALID[k] = rv[k];
            S_RID[k*W_SID +: W_SID] = rsid[k];
            S_RDATA[k*W_DATA +: W_DATA] = rdat[k];
            S_RRESP[k*2 +: 2] = rresp[k];
            S_RLAST[k] = (rleft[k] == 1);
        end
        if (stall_b > 0) begin
            m.M_BREADY = 1'b0; stall_b--;
        end else begin
            m.M_BREADY = ($urandom % 4) != 0;
            if ($urandom % 30 == 0) stall_b = 5;
        end
        if (rr_hold_low) m.M_RREADY = 1'b0;
        else if (stall_r > 0) begin
            m.M_RREADY = 1'b0; stall_r--;
        end else begin
            m.M_RREADY = ($urandom % 4) != 0;
            if ($urandom % 30 == 0) stall_r = 5;
        end
        if ($urandom % 8 == 0) R_ORDER_MASK = NUM_S'($urandom);
        if ($urandom % 40 == 0) ARB_MODE = ~ARB_MODE;
    endtask

    task automatic model_eval();
        bit [N-1:0] breq, rreq, hreq, elig, exp_br, exp_rr;
        int gb, gr;
        if (AXI_RST) begin
            check("s_bready_rst", 64'(S_BREADY), 64'd0);
            check("s_rready_rst", 64'(S_RREADY), 64'd0);
            if (rst_seen)
                check("m_outputs_rst",
                      64'({m.M_BVALID, m.M_RVALID, m.M_BID, m.M_BRESP, m.M_RSID,
                           m.M_RDATA, m.M_RRESP, m.M_RLAST}), 64'd0);
            rst_seen = 1'b1;
            model_clear();
            return;
        end
        rst_seen = 1'b0;
        check("m_bvalid", 64'(m.M_BVALID), 64'(bcnt != 0));
        check("m_rvalid", 64'(m.M_RVALID), 64'(rcnt != 0));

        elig = {1'b1, R_ORDER_MASK};
        for (int k = 0; k < N; k++) begin
            breq[k] = bv[k] && (mid_of(bsid[k]) == int'(M_MID));
            hreq[k] = rv[k] && (mid_of(rsid[k]) == int'(M_MID));
            rreq[k] = hreq[k] && elig[k];
        end
        gb = pick(breq, bptr, ARB_MODE == ARB_RR);
        if (rlocked) gr = hreq[rheld] ? rheld : -1;
        else         gr = pick(rreq, rptr, ARB_MODE == ARB_RR);
        exp_br = (gb >= 0 && bcnt < 2) ? (N'(1) << gb) : '0;
        exp_rr = (gr >= 0 && rcnt < 2) ? (N'(1) << gr) : '0;
        check("s_bready", 64'(S_BREADY), 64'(exp_br));
        check("s_rready", 64'(S_RREADY), 64'(exp_rr));

        if (bcnt > 0 && m.M_BREADY) bcnt--;
        if (rcnt > 0 && m.M_RREADY) rcnt--;
        if (exp_br != 0) begin
            bexp.push_back({bsid[gb][W_ID-1:0], bresp[gb]});
            bptr = (gb + 1) % N;
            bv[gb] = 1'b0;
            bcnt++;
        end
        if (exp_rr != 0) begin
            rexp.push_back({rsid[gr], rdat[gr], rresp[gr], 1'(rleft[gr] == 1)});
            if (rleft[gr] == 1) begin
                rlocked = 1'b0;
                rptr = (gr + 1) % N;
            end else if (!rlocked) begin
                rlocked = 1'b1;
                rheld = gr;
            end
            rv[gr] = 1'b0;
            rleft[gr]--;
            rcnt++;
        end

        // Slave behaviour for next cycle. Foreign-MID beats are taken by
        // some other master's router after a while.
        for (int k = 0; k < N; k++) begin
            if (bv[k] && mid_of(bsid[k]) != int'(M_MID) && $urandom % 3 == 0) bv[k] = 1'b0;
            if (!bv[k] && $urandom % 3 == 0) begin
                bv[k] = 1'b1; bsid[k] = rand_sid(); bresp[k] = 2'($urandom);
            end
            if (rv[k] && mid_of(rsid[k]) != int'(M_MID) && $urandom % 3 == 0) begin
                rv[k] = 1'b0; rleft[k]--;
            end
            if (!rv[k]) begin
                if (rleft[k] == 0 && $urandom % 3 == 0) begin
                    rleft[k] = int'($urandom_range(1, 4));
                    rsid[k] = rand_sid();
                end
                if (rleft[k] > 0 && $urandom % 4 != 0) begin
                    rv[k] = 1'b1; rdat[k] = $urandom; rresp[k] = 2'($urandom);
                end
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge AXI_CLK);
        model_eval();
        @(posedge AXI_CLK);
        #1;
    endtask

    // Monitor: every beat the master takes is matched against the scoreboard.
    always @(negedge AXI_CLK) begin
        if (!AXI_RST) begin
            if (m.M_BVALID && m.M_BREADY) begin
                if (bexp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_beat: got %0h expected none", {m.M_BID, m.M_BRESP});
                end else
                    check("b_beat", 64'({m.M_BID, m.M_BRESP}), 64'(bexp.pop_front()));
            end
            if (m.M_RVALID && m.M_RREADY) begin
                if (rexp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_beat: got %0h expected none",
                             {m.M_RSID, m.M_RDATA, m.M_RRESP, m.M_RLAST});
                end else
                    check("r_beat", 64'({m.M_RSID, m.M_RDATA, m.M_RRESP, m.M_RLAST}),
                          64'(rexp.pop_front()));
            end
        end
    end

    initial begin
        int n;
        M_MID = 2'd2;
        ARB_MODE = ARB_FIXED;
        R_ORDER_MASK = '1;
        m.M_BREADY = 1'b0;
        m.M_RREADY = 1'b0;
        rr_hold_low = 1'b0;
        stall_b = 0; stall_r = 0; rst_seen = 1'b0;
        for (int k = 0; k < N; k++) begin
            bsid[k] = '0; bresp[k] = '0; rsid[k] = '0; rdat[k] = '0; rresp[k] = '0;
        end
        model_clear();

        AXI_RST = 1'b1;
        repeat (3) step();
        AXI_RST = 1'b0;
        repeat (2500) step();

        // Fill the R buffer with the master stalled, then reset mid-stream.
        rr_hold_low = 1'b1;
        n = 0;
        while (rcnt != 2 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (rcnt != 2) begin
            errors++;
            $display("FAIL rst_setup: buffered %0d expected 2 within 300 cycles", rcnt);
        end
        repeat (3) step();
        AXI_RST = 1'b1;
        repeat (2) step();
        AXI_RST = 1'b0;
        rr_hold_low = 1'b0;
        repeat (2500) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
